sent_tx_scheduler: RTL

Front-end scheduler for the SENT transmitter. Shares the single `sent_tx_control` instance among `NUM_REQ` sensor requesters using round-robin arbitration. For the winner it latches the frame configuration, issues the start pulse, and holds the configuration stable until the transmitter reports the frame sequence finished. An optional watchdog aborts sequences that never complete.

---
 rtl/sent_pkg.sv | 20 ++
 rtl/sent_rr_arbiter.sv | 31 +++
 rtl/sent_tx_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sent_pkg.sv
// Shared SENT definitions: channel-format codes, scheduler state encoding
// and the default watchdog limit.
package sent_pkg;

    localparam logic [1:0] FMT_SERIAL   = 2'b00;
    localparam logic [1:0] FMT_ENHANCED = 2'b01;
    localparam logic [1:0] FMT_FAST     = 2'b10;
    localparam logic [1:0] FMT_ILLEGAL  = 2'b11;

    localparam int          SENT_TIMEOUT_W       = 20;
    localparam logic [19:0] SENT_TIMEOUT_DEFAULT = 20'd600000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sent_rr_arbiter.sv
// Combinational round-robin pick: first requester above ptr wins, wrapping
// around. The pointer register is owned by the caller.
module sent_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/sent_tx_scheduler.sv
// Round-robin front end sharing one SENT transmitter among NUM_REQ requesters.
// Optional watchdog abort is built when SENT_SCHED_WATCHDOG_EN is defined.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no grant; arbitrate and latch the winner's configuration
// ST_LAUNCH  | pulse tx_enable_o, or flag an illegal format
// ST_WAIT    | sequence running; wait for tx_idle_i rising edge
// ST_RELEASE | drop the grant and advance the round-robin pointer
module sent_tx_scheduler
    import sent_pkg::*;
#(
    parameter int                    NUM_REQ        = 4,
    parameter int                    TIMEOUT_W      = SENT_TIMEOUT_W,
    parameter logic [TIMEOUT_W-1:0]  TIMEOUT_CYCLES = TIMEOUT_W'(SENT_TIMEOUT_DEFAULT)
) (
    input  logic                  clk_tx,
    input  logic                  reset_tx,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [2*NUM_REQ-1:0]  req_format_i,
    input  logic [8*NUM_REQ-1:0]  req_id_i,
    input  logic [16*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]    req_pause_i,
    input  logic [NUM_REQ-1:0]    req_config_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [NUM_REQ-1:0]    done_o,
    output logic [NUM_REQ-1:0]    err_o,
    output logic                  busy_o,
    output logic                  tx_enable_o,
    output logic [1:0]            tx_channel_format_o,
    output logic [7:0]            tx_id_o,
    output logic [15:0]           tx_data_bit_field_o,
    output logic                  tx_optional_pause_o,
    output logic                  tx_config_bit_o,
    input  logic                  tx_idle_i,
    output logic                  tx_abort_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_t state, state_nxt;

    logic [IDX_W-1:0]   ptr, win_idx, arb_idx;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               arb_valid;
    logic               idle_q, idle_rise, wd_expired;
    logic               grant_en, launch_en, illegal_en, done_en, abort_en, release_en;

    logic [1:0]  sel_fmt;
    logic [7:0]  sel_id;
    logic [15:0] sel_data;
    logic        sel_pause, sel_cfg;

    sent_rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req   (req_i),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        sel_fmt   = '0;
        sel_id    = '0;
        sel_data  = '0;
        sel_pause = 1'b0;
        sel_cfg   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_fmt   = req_format_i[2*i +: 2];
                sel_id    = req_id_i[8*i +: 8];
                sel_data  = req_data_i[16*i +: 16];
                sel_pause = req_pause_i[i];
                sel_cfg   = req_config_i[i];
            end
        end
    end

    // The transmitter drops idle on start, so only a fresh rise ends WAIT.
    assign idle_rise = tx_idle_i & ~idle_q;
    assign busy_o    = (state != ST_IDLE);

    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant_en   = 1'b0;
        launch_en  = 1'b0;
        illegal_en = 1'b0;
        done_en    = 1'b0;
        abort_en   = 1'b0;
        release_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) begin
                    grant_en  = 1'b1;
                    state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (tx_channel_format_o == FMT_ILLEGAL) begin
                    illegal_en = 1'b1;
                    state_nxt  = ST_RELEASE;
                end else begin
                    launch_en = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (idle_rise) begin
                    done_en   = 1'b1;
                    state_nxt = ST_RELEASE;
                end else if (wd_expired) begin
                    abort_en  = 1'b1;
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                release_en = 1'b1;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            ptr                 <= IDX_W'(NUM_REQ - 1);
            win_idx             <= '0;
            idle_q              <= 1'b0;
            gnt_o               <= '0;
            done_o              <= '0;
            err_o               <= '0;
            tx_enable_o         <= 1'b0;
            tx_channel_format_o <= '0;
            tx_id_o             <= '0;
            tx_data_bit_field_o <= '0;
            tx_optional_pause_o <= 1'b0;
            tx_config_bit_o     <= 1'b0;
        end else begin
            idle_q      <= tx_idle_i;
            tx_enable_o <= launch_en;
            done_o      <= done_en ? gnt_o : '0;
            err_o       <= (illegal_en | abort_en) ? gnt_o : '0;
            if (grant_en) begin
                gnt_o               <= arb_gnt;
                win_idx             <= arb_idx;
                tx_channel_format_o <= sel_fmt;
                tx_id_o             <= sel_id;
                tx_data_bit_field_o <= sel_data;
                tx_optional_pause_o <= sel_pause;
                tx_config_bit_o     <= sel_cfg;
            end
            if (release_en) begin
                gnt_o <= '0;
                ptr   <= win_idx;
            end
        end
    end

`ifdef SENT_SCHED_WATCHDOG_EN
    // Down-counter loaded at launch; terminal count fires on WAIT cycle TIMEOUT_CYCLES.
    logic [TIMEOUT_W-1:0] wd_cnt;

    always_ff @(posedge clk_tx or posedge reset_tx) begin
        if (reset_tx) begin
            wd_cnt     <= '0;
            tx_abort_o <= 1'b0;
        end else begin
            tx_abort_o <= abort_en;
            if (launch_en)
                wd_cnt <= TIMEOUT_CYCLES - TIMEOUT_W'(1);
            else if (state == ST_WAIT && wd_cnt != '0)
                wd_cnt <= wd_cnt - TIMEOUT_W'(1);
        end
    end

    assign wd_expired = (state == ST_WAIT) && (wd_cnt == '0);
`else
    assign wd_expired = 1'b0;
    assign tx_abort_o = 1'b0;
`endif

endmodule
